// File: rtl/piso8_pkg.sv
// Shared definitions for the piso8 serializer: FSM states, default width and
// bit-counter sizing.
package piso8_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } txState_t;

    localparam int unsigned PISO8_WIDTH = 8;

    function automatic int unsigned cntWidth(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned PISO8_CNT_W = cntWidth(PISO8_WIDTH);

endpackage

// File: rtl/piso8_hold.sv
// One-entry holding buffer that sits in front of the piso8 shifter.
module piso8_hold
    import piso8_pkg::*;
#(
    parameter int unsigned WIDTH = PISO8_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            if (push) begin
                data <= din;
            end
            if (push) begin
                full <= 1'b1;
            end else if (pop) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/piso8_tx.sv
// Parallel-in serial-out transmitter with one-word hold buffer and bypass path.
// Optional even parity bit per frame when PISO8_TX_PARITY_EN is defined.
module piso8_tx
    import piso8_pkg::*;
#(
    parameter int unsigned WIDTH      = PISO8_WIDTH,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I,
    input  logic             I_valid,
    output logic             I_ready,
    output logic             O,
    output logic             O_valid,
    output logic             O_last
);

`ifdef PISO8_TX_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam int unsigned CW = cntWidth(WIDTH);

    txState_t         state, stateNext;
    logic [WIDTH-1:0] sh, shNext;
    logic [CW-1:0]    cnt, cntNext;
    logic             oNext, oValidNext, oLastNext;
    logic             holdFull, holdPush, holdPop;
    logic [WIDTH-1:0] holdData;
    logic             lastBit, canLoad, accept, doLoad;
    logic [WIDTH-1:0] loadWord;
`ifdef PISO8_TX_PARITY_EN
    logic             par, parNext;
`endif

    function automatic logic headBit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    piso8_hold #(.WIDTH(WIDTH)) uHold (
        .clk   (CLK),
        .reset (RESET),
        .push  (holdPush),
        .pop   (holdPop),
        .din   (I),
        .data  (holdData),
        .full  (holdFull)
    );

    assign lastBit = (state == SHIFT) && (cnt == '0);
    assign canLoad = (state == IDLE) || lastBit;
    assign holdPop = canLoad && holdFull;
    // A draining hold frees its slot on the same edge, so a new word may enter
    // on the last-bit cycle without opening a gap in the stream.
    assign I_ready = !RESET && (!holdFull || holdPop);
    assign accept  = I_valid && I_ready;

    always_comb begin
        stateNext  = state;
        shNext     = sh;
        cntNext    = cnt;
        oNext      = IDLE_LEVEL;
        oValidNext = 1'b0;
        oLastNext  = 1'b0;
        holdPush   = 1'b0;
        doLoad     = 1'b0;
        loadWord   = I;
`ifdef PISO8_TX_PARITY_EN
        parNext    = par;
`endif

        if (holdPop) begin
            doLoad   = 1'b1;
            loadWord = holdData;
            holdPush = accept;
        end else if (canLoad && accept) begin
            doLoad   = 1'b1;
        end else begin
            holdPush = accept;
        end

        if (doLoad) begin
            stateNext  = SHIFT;
            oNext      = headBit(loadWord);
            shNext     = advance(loadWord);
            cntNext    = CW'(FRAME - 1);
            oValidNext = 1'b1;
`ifdef PISO8_TX_PARITY_EN
            parNext    = ^loadWord;
`endif
        end else if (state == SHIFT && !lastBit) begin
            cntNext    = cnt - 1'b1;
            shNext     = advance(sh);
            oValidNext = 1'b1;
            oLastNext  = (cnt == CW'(1));
`ifdef PISO8_TX_PARITY_EN
            oNext      = (cnt == CW'(1)) ? par : headBit(sh);
`else
            oNext      = headBit(sh);
`endif
        end else if (lastBit) begin
            stateNext  = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            sh      <= '0;
            cnt     <= '0;
            O       <= IDLE_LEVEL;
            O_valid <= 1'b0;
            O_last  <= 1'b0;
`ifdef PISO8_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= stateNext;
            sh      <= shNext;
            cnt     <= cntNext;
            O       <= oNext;
            O_valid <= oValidNext;
            O_last  <= oLastNext;
`ifdef PISO8_TX_PARITY_EN
            par     <= parNext;
`endif
        end
    end

endmodule

// File: tb/tb_piso8_tx.sv
// Directed scoreboard bench for piso8_tx: an MSB-first instance (idle low) and
// an LSB-first instance (idle high) checked bit by bit against a queue model.
module tb_piso8_tx;

`ifdef PISO8_TX_PARITY_EN
    localparam int unsigned FRAME = 9;
`else
    localparam int unsigned FRAME = 8;
`endif

    typedef struct packed {
        logic last;
        logic b;
    } expBit_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] iM, iL;
    logic       iValidM, iValidL, iReadyM, iReadyL;
    logic       oM, oValidM, oLastM, oL, oValidL, oLastL;

    expBit_t qM[$];
    expBit_t qL[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    piso8_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dutM (
        .CLK(clk), .RESET(rst), .I(iM), .I_valid(iValidM), .I_ready(iReadyM),
        .O(oM), .O_valid(oValidM), .O_last(oLastM)
    );

    piso8_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dutL (
        .CLK(clk), .RESET(rst), .I(iL), .I_valid(iValidL), .I_ready(iReadyL),
        .O(oL), .O_valid(oValidL), .O_last(oLastL)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic expBit_t bitAt(input logic [7:0] w, input bit msb, input int unsigned k);
        expBit_t e;
        logic [2:0] idx;
        idx    = msb ? 3'(7 - k) : 3'(k);
        e.last = (k == FRAME - 1);
        e.b    = (k >= 8) ? ^w : w[idx];
        return e;
    endfunction

    task automatic pushM(input logic [7:0] w);
        for (int unsigned k = 0; k < FRAME; k++) qM.push_back(bitAt(w, 1'b1, k));
    endtask

    task automatic pushL(input logic [7:0] w);
        for (int unsigned k = 0; k < FRAME; k++) qL.push_back(bitAt(w, 1'b0, k));
    endtask

    // Advance one clock and score both serial outputs against the queues.
    task automatic tick();
        expBit_t e;
        @(posedge clk);
        #1;
        if (oValidM) begin
            if (qM.size() == 0) chk("M_extra_bit", oValidM, 1'b0);
            else begin
                e = qM.pop_front();
                chk("M_bit", {oLastM, oM}, {e.last, e.b});
            end
        end else chk("M_idle", {oLastM, oM}, 2'b00);
        if (oValidL) begin
            if (qL.size() == 0) chk("L_extra_bit", oValidL, 1'b0);
            else begin
                e = qL.pop_front();
                chk("L_bit", {oLastL, oL}, {e.last, e.b});
            end
        end else chk("L_idle", {oLastL, oL}, 2'b01);
    endtask

    initial begin
        rst = 1'b1; iM = '0; iL = '0; iValidM = 1'b0; iValidL = 1'b0;
        #1;
        chk("rst_ready_M", iReadyM, 1'b0);
        chk("rst_ready_L", iReadyL, 1'b0);
        tick();
        tick();
        chk("rst_valid_M", oValidM, 1'b0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst_M", iReadyM, 1'b1);
        chk("ready_after_rst_L", iReadyL, 1'b1);

        // single word 0xA5 MSB-first, 0x01 LSB-first in parallel
        iM = 8'hA5; iValidM = 1'b1; pushM(8'hA5);
        iL = 8'h01; iValidL = 1'b1; pushL(8'h01);
        tick();
        iValidM = 1'b0; iValidL = 1'b0;
        for (int unsigned c = 1; c <= FRAME; c++) begin
            chk("single_valid_M", oValidM, 1'b1);
            chk("single_valid_L", oValidL, 1'b1);
            if (c < FRAME) tick();
        end
        chk("single_last_M", oLastM, 1'b1);
        tick();
        chk("single_idle_M", oValidM, 1'b0);
        chk("single_idle_L", oValidL, 1'b0);
        chk("single_drain_M", qM.size(), 0);
        chk("single_drain_L", qL.size(), 0);

        // back-to-back 0x0F then 0xF0
        tick();
        iM = 8'h0F; iValidM = 1'b1;
        #1 chk("b2b_ready_w1", iReadyM, 1'b1);
        pushM(8'h0F);
        tick();
        chk("b2b_valid", oValidM, 1'b1);
        iM = 8'hF0;
        #1 chk("b2b_ready_w2", iReadyM, 1'b1);
        pushM(8'hF0);
        tick();
        iValidM = 1'b0;
        for (int unsigned c = 2; c <= 2 * FRAME; c++) begin
            chk("b2b_valid", oValidM, 1'b1);
            if (c < FRAME) chk("b2b_hold_ready", iReadyM, 1'b0);
            if (c < 2 * FRAME) tick();
        end
        tick();
        chk("b2b_idle", oValidM, 1'b0);
        chk("b2b_drain", qM.size(), 0);

        // backpressure: three words offered back to back
        tick();
        iM = 8'h3C; iValidM = 1'b1;
        #1 chk("bp_ready_w1", iReadyM, 1'b1);
        pushM(8'h3C);
        tick();
        iM = 8'hA6;
        #1 chk("bp_ready_w2", iReadyM, 1'b1);
        pushM(8'hA6);
        tick();
        for (int unsigned c = 2; c < FRAME; c++) begin
            chk("bp_valid", oValidM, 1'b1);
            iM = 8'h5B;
            #1 chk("bp_ready_blocked", iReadyM, 1'b0);
            tick();
        end
        chk("bp_last_w1", oLastM, 1'b1);
        #1 chk("bp_ready_w3", iReadyM, 1'b1);
        pushM(8'h5B);
        tick();
        iValidM = 1'b0;
        for (int unsigned c = FRAME + 1; c <= 3 * FRAME; c++) begin
            chk("bp_valid", oValidM, 1'b1);
            if (c < 3 * FRAME) tick();
        end
        tick();
        chk("bp_idle", oValidM, 1'b0);
        chk("bp_drain", qM.size(), 0);

        // reset at bit 4 of 0xFF with 0x55 held
        tick();
        iM = 8'hFF; iValidM = 1'b1;
        for (int unsigned k = 0; k < 4; k++) qM.push_back(bitAt(8'hFF, 1'b1, k));
        tick();
        iM = 8'h55;
        #1 chk("rst_mid_ready_hold", iReadyM, 1'b1);
        tick();
        iValidM = 1'b0;
        tick();
        tick();
        chk("rst_mid_bit4_valid", oValidM, 1'b1);
        rst = 1'b1;
        #1 chk("rst_mid_ready", iReadyM, 1'b0);
        tick();
        chk("rst_mid_valid", oValidM, 1'b0);
        chk("rst_mid_level", oM, 1'b0);
        rst = 1'b0;
        #1 chk("rst_mid_ready_after", iReadyM, 1'b1);
        repeat (2 * FRAME + 2) tick();
        chk("rst_mid_no_stale", qM.size(), 0);

        // parity patterns 0x07 and 0x03
        for (int unsigned n = 0; n < 2; n++) begin
            iM = (n == 0) ? 8'h07 : 8'h03;
            iValidM = 1'b1;
            pushM(iM);
            tick();
            iValidM = 1'b0;
            repeat (FRAME) tick();
            chk("par_idle", oValidM, 1'b0);
        end

        chk("final_drain_M", qM.size(), 0);
        chk("final_drain_L", qL.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
